// File: rtl/audio_pkg.sv
// Shared constants and FSM state encoding for the audio frame-to-stream adapter.
package audio_pkg;

    localparam int DATA_W    = 16;
    localparam int FRAME_LEN = 32;
    localparam int IDX_W     = $clog2(FRAME_LEN);
    localparam int ADDR_W    = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        WAIT   = 2'd2
    } stream_state_t;

endpackage

// File: rtl/audio_frame_streamer_frame_bank.sv
// Ping-pong sample store: two frames of FRAME_LEN samples, one write port and
// one registered read port that holds its value while reads are paused.
module audio_frame_streamer_frame_bank
    import audio_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic                     wr_bank,
    input  logic [IDX_W-1:0]         wr_idx,
    input  logic signed [DATA_W-1:0] wr_data,
    input  logic                     rd_en,
    input  logic                     rd_bank,
    input  logic [IDX_W-1:0]         rd_idx,
    output logic signed [DATA_W-1:0] rd_data
);

    logic signed [DATA_W-1:0] mem [2][FRAME_LEN];

    // NOTE: the sample array is deliberately left out of reset so it maps onto
    // plain RAM; every slot is rewritten before a frame is committed anyway.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_bank][wr_idx] <= wr_data;
        end
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values, independent of process ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_bank][rd_idx];
        end
    end

endmodule

// File: rtl/audio_frame_streamer.sv
// Frame-to-stream adapter: upstream fills a ping-pong bank, each committed frame
// is replayed one sample per enabled cycle, and downstream acks free the bank.
module audio_frame_streamer
    import audio_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [IDX_W-1:0]         wr_idx,
    input  logic signed [DATA_W-1:0] wr_data,
    input  logic                     prev_module_done,
    input  logic [ADDR_W-1:0]        address_in,
    output logic                     ready_for_data,
    input  logic                     enable,
    output logic                     stream_valid,
    output logic signed [DATA_W-1:0] stream_data,
    output logic [IDX_W-1:0]         sample_idx,
    output logic                     frame_last,
    output logic                     done,
    output logic [ADDR_W-1:0]        address_out,
    input  logic                     next_module_ready,
    output logic                     overrun
);

    logic [1:0]        full;
    logic              wb;
    logic              rb;
    logic [ADDR_W-1:0] tag [2];

    stream_state_t     state, state_nxt;
    logic [IDX_W-1:0]  idx, idx_nxt;
    logic [IDX_W-1:0]  sample_idx_nxt;
    logic [ADDR_W-1:0] address_out_nxt;
    logic              valid_nxt;
    logic              last_nxt;
    logic              done_nxt;
    logic              rd_en;
    logic              release_bank;
    logic              write_ok;
    logic              commit_ok;

    assign ready_for_data = ~full[wb];
    assign write_ok       = wr_en & ready_for_data;
    assign commit_ok      = prev_module_done & ready_for_data;

    // A release and a commit in the same cycle always touch different banks:
    // rb == wb only when that bank is full, which blocks the commit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full    <= '0;
            wb      <= 1'b0;
            rb      <= 1'b0;
            overrun <= 1'b0;
            for (int b = 0; b < 2; b++) begin
                tag[b] <= '0;
            end
        end else begin
            if (commit_ok) begin
                full[wb] <= 1'b1;
                tag[wb]  <= address_in;
                wb       <= ~wb;
            end
            if (release_bank) begin
                full[rb] <= 1'b0;
                rb       <= ~rb;
            end
            if (prev_module_done && !ready_for_data) begin
                overrun <= 1'b1;
            end
        end
    end

    // NOTE: every signal driven here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_nxt       = state;
        idx_nxt         = idx;
        sample_idx_nxt  = sample_idx;
        address_out_nxt = address_out;
        valid_nxt       = 1'b0;
        last_nxt        = 1'b0;
        done_nxt        = 1'b0;
        rd_en           = 1'b0;
        release_bank    = 1'b0;
        case (state)
            IDLE: begin
                if (full[rb] && enable) begin
                    state_nxt       = STREAM;
                    idx_nxt         = '0;
                    address_out_nxt = tag[rb];
                end
            end
            STREAM: begin
                if (enable) begin
                    rd_en          = 1'b1;
                    valid_nxt      = 1'b1;
                    sample_idx_nxt = idx;
                    last_nxt       = (idx == IDX_W'(FRAME_LEN - 1));
                    idx_nxt        = idx + 1'b1;
                    if (last_nxt) begin
                        state_nxt = WAIT;
                    end
                end
            end
            WAIT: begin
                done_nxt        = 1'b1;
                address_out_nxt = tag[rb];
                // Only an ack seen while done is visible releases the bank.
                if (done && next_module_ready) begin
                    done_nxt     = 1'b0;
                    release_bank = 1'b1;
                    state_nxt    = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            idx          <= '0;
            stream_valid <= 1'b0;
            sample_idx   <= '0;
            frame_last   <= 1'b0;
            done         <= 1'b0;
            address_out  <= '0;
        end else begin
            state        <= state_nxt;
            idx          <= idx_nxt;
            stream_valid <= valid_nxt;
            sample_idx   <= sample_idx_nxt;
            frame_last   <= last_nxt;
            done         <= done_nxt;
            address_out  <= address_out_nxt;
        end
    end

    audio_frame_streamer_frame_bank u_bank (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (write_ok),
        .wr_bank (wb),
        .wr_idx  (wr_idx),
        .wr_data (wr_data),
        .rd_en   (rd_en),
        .rd_bank (rb),
        .rd_idx  (idx),
        .rd_data (stream_data)
    );

endmodule

// File: tb/tb_audio_frame_streamer.sv
// Directed bench for audio_frame_streamer: ramp latency, overrun, enable gaps,
// ack bubble, mid-stream reset and multi-frame sine continuity.
module tb_audio_frame_streamer;
    import audio_pkg::*;

    logic                     clk = 1'b0;
    logic                     rst = 1'b1;
    logic                     wr_en = 1'b0;
    logic [IDX_W-1:0]         wr_idx = '0;
    logic signed [DATA_W-1:0] wr_data = '0;
    logic                     prev_module_done = 1'b0;
    logic [ADDR_W-1:0]        address_in = '0;
    logic                     ready_for_data;
    logic                     enable = 1'b0;
    logic                     stream_valid;
    logic signed [DATA_W-1:0] stream_data;
    logic [IDX_W-1:0]         sample_idx;
    logic                     frame_last;
    logic                     done;
    logic [ADDR_W-1:0]        address_out;
    logic                     next_module_ready = 1'b0;
    logic                     overrun;

    int total = 0;
    int bad   = 0;

    logic signed [DATA_W-1:0] fbuf [FRAME_LEN];
    logic signed [DATA_W-1:0] exp_q [$];
    logic [ADDR_W-1:0]        tag_q [$];

    audio_frame_streamer dut (
        .clk               (clk),
        .rst               (rst),
        .wr_en             (wr_en),
        .wr_idx            (wr_idx),
        .wr_data           (wr_data),
        .prev_module_done  (prev_module_done),
        .address_in        (address_in),
        .ready_for_data    (ready_for_data),
        .enable            (enable),
        .stream_valid      (stream_valid),
        .stream_data       (stream_data),
        .sample_idx        (sample_idx),
        .frame_last        (frame_last),
        .done              (done),
        .address_out       (address_out),
        .next_module_ready (next_module_ready),
        .overrun           (overrun)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_ramp(input int base, input int step);
        for (int i = 0; i < FRAME_LEN; i++) begin
            fbuf[i] = DATA_W'(base + i * step);
        end
    endtask

    task automatic fill_sine(input int frame);
        real ph;
        for (int i = 0; i < FRAME_LEN; i++) begin
            ph = 2.0 * 3.14159265358979 * real'(frame * FRAME_LEN + i) * 1188.0 / 45056.0;
            fbuf[i] = DATA_W'($rtoi(32767.0 * $sin(ph)));
        end
    endtask

    // Writes fbuf, then pulses the commit; accepted frames join the model queue.
    task automatic write_commit(input logic [ADDR_W-1:0] tag, input bit accept, input string name);
        for (int i = 0; i < FRAME_LEN; i++) begin
            wr_en   = 1'b1;
            wr_idx  = IDX_W'(i);
            wr_data = fbuf[i];
            tick();
        end
        wr_en = 1'b0;
        total++;
        if (ready_for_data !== accept) begin
            bad++;
            $display("FAIL %s_ready: got %b want %b", name, ready_for_data, accept);
        end
        prev_module_done = 1'b1;
        address_in       = tag;
        tick();
        prev_module_done = 1'b0;
        if (accept) begin
            for (int i = 0; i < FRAME_LEN; i++) exp_q.push_back(fbuf[i]);
            tag_q.push_back(tag);
        end
    endtask

    // Consumes one frame from the stream starting at the current cycle.
    task automatic check_frame(input bit toggle, input bit do_ack, input string name,
                               output int done_lat);
        int i;
        int cycles;
        bit en_edge;
        logic signed [DATA_W-1:0] exp_d;
        logic [ADDR_W-1:0] exp_tag;
        i = 0;
        cycles = 0;
        en_edge = 1'b1;
        done_lat = 0;
        if (exp_q.size() < FRAME_LEN || tag_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL %s_model: queued %0d samples, need %0d", name, exp_q.size(), FRAME_LEN);
            return;
        end
        while (i < FRAME_LEN && cycles < 400) begin
            if (toggle && i > 0) begin
                total++;
                if (stream_valid !== en_edge) begin
                    bad++;
                    $display("FAIL %s_valid_follow: got %b want %b at sample %0d", name, stream_valid, en_edge, i);
                end
            end
            if (stream_valid === 1'b1) begin
                exp_d = exp_q.pop_front();
                total++;
                if (sample_idx !== IDX_W'(i)) begin
                    bad++;
                    $display("FAIL %s_idx: got %0d want %0d", name, sample_idx, i);
                end
                total++;
                if (stream_data !== exp_d) begin
                    bad++;
                    $display("FAIL %s_data[%0d]: got %h want %h", name, i, stream_data, exp_d);
                end
                total++;
                if (frame_last !== (i == FRAME_LEN - 1)) begin
                    bad++;
                    $display("FAIL %s_last[%0d]: got %b want %b", name, i, frame_last, (i == FRAME_LEN - 1));
                end
                i++;
            end
            if (i < FRAME_LEN) begin
                en_edge = enable;
                tick();
                cycles++;
                if (toggle) enable = ~enable;
            end
        end
        if (toggle) enable = 1'b1;
        total++;
        if (i != FRAME_LEN) begin
            bad++;
            $display("FAIL %s_timeout: got %0d samples want %0d", name, i, FRAME_LEN);
        end
        while (done !== 1'b1 && done_lat < 10) begin
            tick();
            done_lat++;
        end
        exp_tag = tag_q.pop_front();
        total++;
        if (done !== 1'b1) begin
            bad++;
            $display("FAIL %s_done: got %b want 1", name, done);
        end
        total++;
        if (address_out !== exp_tag) begin
            bad++;
            $display("FAIL %s_tag: got %h want %h", name, address_out, exp_tag);
        end
        if (do_ack) begin
            next_module_ready = 1'b1;
            tick();
            next_module_ready = 1'b0;
            total++;
            if (done !== 1'b0) begin
                bad++;
                $display("FAIL %s_ack: done got %b want 0", name, done);
            end
        end
    endtask

    task automatic test_reset();
        total++;
        if ({stream_valid, frame_last, done, overrun, ready_for_data} !== 5'b00001) begin
            bad++;
            $display("FAIL reset_flags: got %b want 00001", {stream_valid, frame_last, done, overrun, ready_for_data});
        end
        total++;
        if ({stream_data, sample_idx, address_out} !== '0) begin
            bad++;
            $display("FAIL reset_values: got data=%h idx=%0d addr=%h want 0", stream_data, sample_idx, address_out);
        end
    endtask

    task automatic test_ramp();
        int lat;
        enable = 1'b1;
        next_module_ready = 1'b1;
        fill_ramp(0, 1);
        write_commit(32'h0000_1000, 1'b1, "ramp");
        total++;
        if (stream_valid !== 1'b0) begin
            bad++;
            $display("FAIL ramp_lat_k: valid got %b want 0", stream_valid);
        end
        tick();
        total++;
        if (stream_valid !== 1'b0) begin
            bad++;
            $display("FAIL ramp_lat_k1: valid got %b want 0", stream_valid);
        end
        tick();
        total++;
        if (stream_valid !== 1'b1) begin
            bad++;
            $display("FAIL ramp_lat_k2: valid got %b want 1", stream_valid);
        end
        check_frame(1'b0, 1'b1, "ramp", lat);
        total++;
        if (lat != 1) begin
            bad++;
            $display("FAIL ramp_done_lat: got %0d want 1", lat);
        end
        next_module_ready = 1'b0;
        total++;
        if (ready_for_data !== 1'b1) begin
            bad++;
            $display("FAIL ramp_ready_after: got %b want 1", ready_for_data);
        end
    endtask

    task automatic test_overrun();
        enable = 1'b0;
        fill_ramp(256, 3);
        write_commit(32'h10, 1'b1, "frame_a");
        fill_ramp(-4096, 7);
        write_commit(32'h20, 1'b1, "frame_b");
        total++;
        if ({ready_for_data, overrun} !== 2'b00) begin
            bad++;
            $display("FAIL both_full: ready/overrun got %b want 00", {ready_for_data, overrun});
        end
        fill_ramp(16'h5555, 1);
        write_commit(32'h30, 1'b0, "frame_c");
        total++;
        if ({ready_for_data, overrun, done, stream_valid} !== 4'b0100) begin
            bad++;
            $display("FAIL overrun_set: ready/overrun/done/valid got %b want 0100",
                     {ready_for_data, overrun, done, stream_valid});
        end
    endtask

    task automatic test_enable_toggle();
        int lat;
        enable = 1'b1;
        check_frame(1'b1, 1'b0, "toggle_a", lat);
    endtask

    task automatic test_ack_bubble();
        int lat;
        total++;
        if (ready_for_data !== 1'b0) begin
            bad++;
            $display("FAIL bubble_pre_ready: got %b want 0", ready_for_data);
        end
        next_module_ready = 1'b1;
        tick();
        next_module_ready = 1'b0;
        total++;
        if ({done, ready_for_data, stream_valid} !== 3'b010) begin
            bad++;
            $display("FAIL bubble_ack: done/ready/valid got %b want 010", {done, ready_for_data, stream_valid});
        end
        tick();
        total++;
        if (stream_valid !== 1'b0) begin
            bad++;
            $display("FAIL bubble_gap: valid got %b want 0", stream_valid);
        end
        tick();
        total++;
        if (stream_valid !== 1'b1) begin
            bad++;
            $display("FAIL bubble_start: valid got %b want 1", stream_valid);
        end
        check_frame(1'b0, 1'b1, "frame_b", lat);
    endtask

    task automatic test_reset_mid();
        int lat;
        int n;
        int stray;
        enable = 1'b1;
        next_module_ready = 1'b0;
        fill_ramp(16'h2000, 2);
        write_commit(32'h50, 1'b1, "frame_r");
        n = 0;
        while (!(stream_valid === 1'b1 && sample_idx == IDX_W'(15)) && n < 100) begin
            tick();
            n++;
        end
        total++;
        if (n >= 100) begin
            bad++;
            $display("FAIL rst_reach15: got idx %0d want 15", sample_idx);
        end
        rst = 1'b1;
        #2;
        total++;
        if ({stream_valid, done, overrun, frame_last, ready_for_data} !== 5'b00001) begin
            bad++;
            $display("FAIL rst_async: valid/done/overrun/last/ready got %b want 00001",
                     {stream_valid, done, overrun, frame_last, ready_for_data});
        end
        exp_q.delete();
        tag_q.delete();
        tick();
        rst = 1'b0;
        stray = 0;
        for (int c = 0; c < 4; c++) begin
            tick();
            if (stream_valid !== 1'b0) stray++;
        end
        total++;
        if (stray != 0) begin
            bad++;
            $display("FAIL rst_no_partial: got %0d valid cycles want 0", stray);
        end
        fill_ramp(-300, -11);
        write_commit(32'h60, 1'b1, "frame_post");
        check_frame(1'b0, 1'b1, "frame_post", lat);
    endtask

    task automatic test_sine();
        int lat;
        enable = 1'b0;
        next_module_ready = 1'b0;
        fill_sine(0);
        write_commit(32'h7000, 1'b1, "sine0");
        fill_sine(1);
        write_commit(32'h7001, 1'b1, "sine1");
        for (int f = 0; f < 8; f++) begin
            enable = 1'b1;
            check_frame(1'b0, 1'b1, "sine", lat);
            enable = 1'b0;
            if (f + 2 < 8) begin
                fill_sine(f + 2);
                write_commit(32'h7000 + ADDR_W'(f + 2), 1'b1, "sine_n");
            end
        end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        rst = 1'b0;
        tick();
        test_reset();
        test_ramp();
        test_overrun();
        test_enable_toggle();
        test_ack_bubble();
        test_reset_mid();
        test_sine();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
